// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART types and helpers: runtime configuration, sequencer state encoding
// and the baud divisor calculation used at frame start.
package uart_tx_ctrl_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 100_000_000;
  localparam int unsigned DIV_WIDTH_DEFAULT   = 20;

  typedef logic [DIV_WIDTH_DEFAULT-1:0] baud_div_t;

  typedef struct packed {
    logic [31:0] baudRate;
    logic        parityEnable;
    logic        parityType;
    logic [1:0]  numStopBits;
  } uart_config_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // A zero baud rate is treated as "as slow as the counter allows".
  function automatic logic [31:0] calc_baud_div(
    input uart_config_t cfg,
    input int unsigned  clk_freq_hz = CLK_FREQ_HZ_DEFAULT,
    input int unsigned  div_width   = DIV_WIDTH_DEFAULT
  );
    logic [31:0] max_div;
    logic [31:0] quot;
    max_div = (div_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << div_width) - 32'd1);
    if (cfg.baudRate == '0) quot = max_div;
    else                    quot = clk_freq_hz / cfg.baudRate;
    if (quot > max_div) quot = max_div;
    if (quot < 32'd2)   quot = 32'd2;
    return quot;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_baud_gen.sv
// Bit-period timer: loaded with the divisor at frame start, free-runs while a
// frame is active and wraps to zero on every bit boundary.
module uart_baud_gen
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 run_i,
  output logic                 bit_end_o
);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] cnt_q;

  assign bit_end_o = run_i && (cnt_q == (div_q - DIV_WIDTH'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) div_q <= div_i;
      if (!run_i || bit_end_o) cnt_q <= '0;
      else                     cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Transmit-side UART frame sequencer: accepts a byte, latches the configuration
// and shifts START, DATA, optional PARITY and STOP bits onto the tx line.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  uart_config_t cfg_i,
  input  logic [7:0]   tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic         tx_o,
  output logic         busy_o,
  output uart_state_t  state_o,
  output logic         frame_done_o
);

  uart_state_t          state_q;
  uart_state_t          state_d;
  logic [7:0]           data_q;
  logic                 parity_en_q;
  logic                 parity_type_q;
  logic                 two_stop_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 accept;
  logic                 run;
  logic                 bit_end;
  logic                 last_stop;
  logic [DIV_WIDTH-1:0] div_calc;

  assign accept    = tx_valid_i && tx_ready_o;
  assign run       = (state_q != IDLE);
  assign div_calc  = DIV_WIDTH'(calc_baud_div(cfg_i, CLK_FREQ_HZ, DIV_WIDTH));
  assign last_stop = !two_stop_q || stop_idx_q;
  assign state_o   = state_q;

  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept),
    .div_i    (div_calc),
    .run_i    (run),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Frame contents are frozen at acceptance so cfg_i changes mid-frame are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q        <= '0;
      parity_en_q   <= 1'b0;
      parity_type_q <= 1'b0;
      two_stop_q    <= 1'b0;
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
    end else if (accept) begin
      data_q        <= tx_data_i;
      parity_en_q   <= cfg_i.parityEnable;
      parity_type_q <= cfg_i.parityType;
      two_stop_q    <= (cfg_i.numStopBits >= 2'd2);
      bit_idx_q     <= '0;
      stop_idx_q    <= 1'b0;
    end else if (bit_end) begin
      if (state_q == DATA) bit_idx_q  <= bit_idx_q + 3'd1;
      if (state_q == STOP) stop_idx_q <= !stop_idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == 3'd7)) state_d = parity_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (bit_end && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_o         = 1'b1;
    tx_ready_o   = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (state_q)
      IDLE:   tx_ready_o = !rst_i;
      START: begin
        tx_o   = 1'b0;
        busy_o = 1'b1;
      end
      DATA: begin
        tx_o   = data_q[bit_idx_q];
        busy_o = 1'b1;
      end
      PARITY: begin
        tx_o   = (^data_q) ^ parity_type_q;
        busy_o = 1'b1;
      end
      STOP: begin
        busy_o       = 1'b1;
        frame_done_o = bit_end && last_stop && !rst_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues hand-written bit strings,
// a negedge monitor compares the serial line cycle by cycle against them.
module tb_uart_tx_ctrl;
  import uart_tx_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  uart_config_t cfg_in;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx;
  logic         busy;
  uart_state_t  state;
  logic         frame_done;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLK_FREQ_HZ(96000),
    .DIV_WIDTH  (20)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_i       (cfg_in),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .state_o     (state),
    .frame_done_o(frame_done)
  );

  string       exp_bits_q[$];
  int unsigned exp_div_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic        in_frame    = 1'b0;
  logic        ready_after = 1'b0;
  string       cur_bits;
  int unsigned cur_div;
  int unsigned cyc;
  int unsigned idx;
  logic        exp_level;
  logic        bad_bits;
  logic        bad_busy;
  int          frame_done_count = 0;
  int          since_done = 0;
  int          last_gap = 0;

  uart_config_t dflt;

  function automatic uart_config_t mk_cfg(input int unsigned baud, input logic pe,
                                          input logic pt, input logic [1:0] ns);
    uart_config_t c;
    c.baudRate     = baud;
    c.parityEnable = pe;
    c.parityType   = pt;
    c.numStopBits  = ns;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: one pass per cycle, on the falling edge.
  always @(negedge clk) begin
    if (frame_done) frame_done_count++;
    if (rst) begin
      in_frame    = 1'b0;
      ready_after = 1'b0;
    end else begin
      since_done++;
      if (ready_after) begin
        checkOutput("ready_after_frame", {29'd0, tx_ready, tx, busy}, 32'b110);
        ready_after = 1'b0;
      end
      if (in_frame) begin
        idx = cyc / cur_div;
        if (idx < cur_bits.len()) begin
          exp_level = (cur_bits[idx] == 8'h31);
          if (tx !== exp_level) bad_bits = 1'b1;
        end else begin
          bad_bits = 1'b1;
        end
        if (busy !== 1'b1 || tx_ready !== 1'b0) bad_busy = 1'b1;
        cyc++;
        if (frame_done) begin
          checkOutput("frame_bits", {31'd0, bad_bits}, 32'd0);
          checkOutput("frame_busy", {31'd0, bad_busy}, 32'd0);
          checkOutput("frame_len", cyc, cur_bits.len() * cur_div);
          in_frame    = 1'b0;
          ready_after = 1'b1;
          since_done  = 0;
        end
      end else if (frame_done) begin
        checks++;
        failures++;
        $display("[TB] FAIL stray_frame_done: got 1, expected 0");
      end
      if (tx_valid && tx_ready) begin
        last_gap = since_done;
        if (exp_bits_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_accept: got data %0h, expected no acceptance", tx_data);
        end else begin
          cur_bits = exp_bits_q.pop_front();
          cur_div  = exp_div_q.pop_front();
          cyc      = 0;
          bad_bits = 1'b0;
          bad_busy = 1'b0;
          in_frame = 1'b1;
        end
      end
    end
  end

  // Queue the expected line pattern, present the byte and wait for acceptance.
  task automatic applyStimulus(input logic [7:0] data, input uart_config_t cfg,
                               input string bits, input int unsigned div, input bit hold);
    int n;
    n = 0;
    exp_bits_q.push_back(bits);
    exp_div_q.push_back(div);
    tx_data  = data;
    cfg_in   = cfg;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 5000);
    if (!tx_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got ready=0, expected ready=1");
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((exp_bits_q.size() != 0 || in_frame || ready_after) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_bits_q.size() != 0 || in_frame || ready_after) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got frames pending, expected idle");
    end
    @(posedge clk);
    #1;
  endtask

  logic lowbad;
  logic highbad;
  int   done_base;

  initial begin
    dflt     = mk_cfg(9600, 1'b0, 1'b0, 2'd0);
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    cfg_in   = dflt;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_ready", {31'd0, tx_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_state", 32'(state), 32'(IDLE));
    checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] T1 default config, 0xA5");
    applyStimulus(8'hA5, dflt, "0101001011", 10, 1'b0);
    waitIdle();

    $display("[TB] T2 parity even/odd");
    applyStimulus(8'hA5, mk_cfg(9600, 1'b1, 1'b0, 2'd0), "01010010101", 10, 1'b0);
    waitIdle();
    applyStimulus(8'hA5, mk_cfg(9600, 1'b1, 1'b1, 2'd0), "01010010111", 10, 1'b0);
    waitIdle();

    $display("[TB] T3 stop bit counts");
    applyStimulus(8'hA5, mk_cfg(9600, 1'b0, 1'b0, 2'd2), "01010010111", 10, 1'b0);
    waitIdle();
    applyStimulus(8'hA5, mk_cfg(9600, 1'b0, 1'b0, 2'd3), "01010010111", 10, 1'b0);
    waitIdle();
    applyStimulus(8'hA5, mk_cfg(9600, 1'b0, 1'b0, 2'd0), "0101001011", 10, 1'b0);
    waitIdle();

    $display("[TB] T4 back-to-back");
    applyStimulus(8'h01, dflt, "0100000001", 10, 1'b1);
    applyStimulus(8'h80, dflt, "0000000011", 10, 1'b0);
    waitIdle();
    checkOutput("b2b_gap", last_gap, 32'd1);

    $display("[TB] T5 config change mid-frame");
    applyStimulus(8'hA5, dflt, "0101001011", 10, 1'b0);
    applyStimulus(8'h3C, mk_cfg(4800, 1'b1, 1'b0, 2'd0), "00011110001", 20, 1'b0);
    waitIdle();

    $display("[TB] divisor clamp to 2");
    applyStimulus(8'h5A, mk_cfg(96000, 1'b0, 1'b0, 2'd0), "0010110101", 2, 1'b0);
    waitIdle();
    applyStimulus(8'h5A, mk_cfg(200000, 1'b0, 1'b0, 2'd0), "0010110101", 2, 1'b0);
    waitIdle();

    $display("[TB] T6 reset during DATA bit 3");
    applyStimulus(8'hFF, dflt, "0111111111", 10, 1'b0);
    repeat (44) @(posedge clk);
    done_base = frame_done_count;
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_tx", {31'd0, tx}, 32'd1);
    checkOutput("abort_state", 32'(state), 32'(IDLE));
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, tx_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    highbad = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) highbad = 1'b1;
    end
    checkOutput("abort_line_idle", {31'd0, highbad}, 32'd0);
    checkOutput("abort_no_done", frame_done_count - done_base, 32'd0);
    checkOutput("abort_ready_back", {31'd0, tx_ready}, 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] T6 baudRate 0 uses maximum divisor");
    applyStimulus(8'h00, mk_cfg(0, 1'b0, 1'b0, 2'd0), "0000000001", 1048575, 1'b0);
    lowbad = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (tx !== 1'b0) lowbad = 1'b1;
    end
    checkOutput("baud0_start_hold", {31'd0, lowbad}, 32'd0);
    checkOutput("baud0_state", 32'(state), 32'(START));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("final_idle", {30'd0, tx, busy}, 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side UART frame sequencer. It accepts parallel bytes over a valid/ready handshake and latches the runtime UART configuration (uart_config_t) at frame start. It then drives the serial line through IDLE, START, DATA, PARITY and STOP, using the shared uart_state_t encoding. It sits between the AXI-side TX buffer and the tx pin.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency used to derive clocks-per-bit.
DIV_WIDTH, 20, width of the baud divisor counter.

Ports:
clk_i  in  1  system clock, all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
cfg_i  in  $bits(uart_config_t)  runtime config; sampled only on byte acceptance.
tx_data_i  in  8  byte to send.
tx_valid_i  in  1  byte available.
tx_ready_o  out  1  controller can accept a byte.
tx_o  out  1  serial line, idle high.
busy_o  out  1  a frame is in progress (state != IDLE).
state_o  out  $bits(uart_state_t)  current state, for debug and coverage.
frame_done_o  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (rst_i high at an edge) gives state IDLE and tx_o=1. All other outputs reset to 0: tx_ready_o, busy_o, frame_done_o, and all counters.
- Reset mid-frame aborts immediately. tx_o returns to 1 on the next cycle and no frame_done_o pulse is produced.
- IDLE:
  - tx_ready_o=1 (except during the reset cycle). tx_o=1.
  - On tx_valid_i & tx_ready_o, latch tx_data_i and cfg_i, compute the divisor, and go to START next cycle.
- Divisor = CLK_FREQ_HZ / cfg.baudRate, integer-truncated, then clamped to [2, 2^DIV_WIDTH-1]. baudRate==0 gives the maximum divisor.
- Each bit holds for exactly divisor cycles. A bit counter counts 0..div-1; the bit ends when the counter reaches div-1.
- START: tx_o=0 for one bit time, then go to DATA.
- DATA:
  - 8 bits, LSB first. tx_o = data[k], k=0..7.
  - After bit 7, go to PARITY if parityEnable, else STOP.
- PARITY: tx_o = ^data XOR parityType (parityType 0 = even, 1 = odd). Lasts one bit time, then go to STOP.
- STOP:
  - tx_o=1 for N bit times. N = 1 if numStopBits is 0 or 1; N = 2 if numStopBits is 2 or 3.
  - frame_done_o pulses on the last cycle of the last stop bit. Next cycle is IDLE.
- Minimum inter-frame gap is 1 IDLE cycle with tx_o=1. A byte presented in that cycle starts its START on the following cycle.
- cfg_i changes while busy have no effect on the current frame.
- tx_ready_o=0 in all non-IDLE states. tx_valid_i is ignored while busy; the source must hold data until ready.
- Frame length in cycles = div × (1 + 8 + parityEnable + N).

Decomposition:
- Add to the shared package:
  - CLK_FREQ_HZ default.
  - Function calc_baud_div(uart_config_t) returning the clamped divisor.
  - Typedef baud_div_t = logic [DIV_WIDTH-1:0].
- Reuse uart_state_t and uart_config_t from the package.
- One sub-module: uart_baud_gen. It is loaded with the divisor and restarted at each bit boundary, and it outputs a bit_end strobe. The FSM and shift register stay in uart_tx_ctrl.

Test Plan:
- All tests use CLK_FREQ_HZ=96000, so baudRate 9600 gives div=10.
- T1: default config, send 0xA5. tx_o is 0, then 1,0,1,0,0,1,0,1, then 1, each held for 10 cycles. frame_done_o pulses at cycle 100 after acceptance; tx_ready_o returns 1 the next cycle.
- T2: parityEnable=1, send 0xA5. parityType=0 gives parity bit 0; parityType=1 gives parity bit 1. Frame is 110 cycles.
- T3: numStopBits=2, then repeat with 3. Stop-high time is 20 cycles in both cases. numStopBits=0 gives 10 cycles.
- T4: tx_valid_i held high with 0x01 then 0x80 back-to-back. Exactly one idle-high cycle between the frames, and each byte is accepted exactly once.
- T5: cfg_i switched to baudRate=4800 and parity on during frame 1. Frame 1 is unchanged; frame 2 uses div=20 with parity, 220 cycles.
- T6: rst_i asserted during DATA bit 3. Next cycle: tx_o=1, state_o=IDLE, busy_o=0, no frame_done_o. baudRate=0 gives div=2^20-1 (check the first bit edge only).
